// File: rtl/rv32i_types.sv
// Shared types for the load/store unit.
//   lsu_op_t     : 4-bit memory opcode; bit 3 set means store, bit 2 set
//                  means zero-extend (unsigned load), bits 1:0 give size.
//   lsq_entry_t  : opcode, effective address and store data of a queued op.
//   lsu_state_t  : memory-side state machine states.
// Helper functions cover alignment checking, store lane masks and load
// data extraction so that the top level stays a plain state machine.
package rv32i_types;

    typedef enum logic [3:0] {
        lb  = 4'd0,
        lh  = 4'd1,
        lw  = 4'd2,
        lbu = 4'd4,
        lhu = 4'd5,
        sb  = 4'd8,
        sh  = 4'd9,
        sw  = 4'd10
    } lsu_op_t;

    typedef struct packed {
        lsu_op_t     opc;
        logic [31:0] addr;
        logic [31:0] data;
    } lsq_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MEM   = 2'd1,
        WB    = 2'd2,
        DRAIN = 2'd3
    } lsu_state_t;

    function automatic logic is_store(input lsu_op_t op);
        return op[3];
    endfunction

    // Halfword ops need addr[0]==0, word ops need addr[1:0]==0.
    function automatic logic is_misaligned(input lsu_op_t op, input logic [1:0] a);
        logic mis;
        mis = 1'b0;
        case (op)
            lh, lhu, sh: mis = a[0];
            lw, sw:      mis = (a != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Byte-lane write strobes for an aligned store.
    function automatic logic [3:0] store_mask(input lsu_op_t op, input logic [1:0] a);
        logic [3:0] m;
        m = 4'h0;
        case (op)
            sb:      m = 4'b0001 << a;
            sh:      m = 4'b0011 << {a[1], 1'b0};
            sw:      m = 4'b1111;
            default: m = 4'h0;
        endcase
        return m;
    endfunction

    // Pick the addressed lanes out of a memory word and extend them.
    // Stores complete with a zero result.
    function automatic logic [31:0] load_extract(input lsu_op_t op, input logic [1:0] a,
                                                 input logic [31:0] rdata);
        logic [31:0] shifted;
        logic [31:0] res;
        shifted = rdata >> {a, 3'b000};
        res     = 32'h0;
        case (op)
            lb:      res = {{24{shifted[7]}}, shifted[7:0]};
            lbu:     res = {24'h0, shifted[7:0]};
            lh:      res = {{16{shifted[15]}}, shifted[15:0]};
            lhu:     res = {16'h0, shifted[15:0]};
            lw:      res = rdata;
            default: res = 32'h0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsq_fifo.sv
// Circular load/store queue.
//   clk, rst_n      : clock, synchronous active-low reset
//   flush           : empties the queue (pointers to 0, all valids cleared)
//   push, push_*    : enqueue request and the entry/tag/ROB id to store
//   pop             : dequeue the head entry
//   full, empty     : occupancy flags derived from wrap-bit pointers
//   head_vld, head_*: head entry, presented combinationally
// A push is ignored while full or flushing; a pop is ignored when the head
// slot is invalid or while flushing, so callers may hold requests loosely.
module lsq_fifo
    import rv32i_types::*;
#(
    parameter int DEPTH = 8,
    parameter int TAG_W = 4,
    parameter int ID_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  lsq_entry_t       push_entry,
    input  logic [TAG_W-1:0] push_tag,
    input  logic [ID_W-1:0]  push_id,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic             head_vld,
    output lsq_entry_t       head_entry,
    output logic [TAG_W-1:0] head_tag,
    output logic [ID_W-1:0]  head_id
);

    localparam int PTR_W = $clog2(DEPTH);

    lsq_entry_t       ent_q [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [ID_W-1:0]  id_q  [DEPTH];
    logic [DEPTH-1:0] vld_q;

    // One extra MSB on each pointer distinguishes full from empty.
    logic [PTR_W:0]   wptr_q;
    logic [PTR_W:0]   rptr_q;
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] rd_idx;
    logic             do_push;
    logic             do_pop;

    assign wr_idx = wptr_q[PTR_W-1:0];
    assign rd_idx = rptr_q[PTR_W-1:0];

    assign full  = (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]) &&
                   (wptr_q[PTR_W] != rptr_q[PTR_W]);
    assign empty = (wptr_q == rptr_q);

    assign head_vld   = vld_q[rd_idx];
    assign head_entry = ent_q[rd_idx];
    assign head_tag   = tag_q[rd_idx];
    assign head_id    = id_q[rd_idx];

    assign do_push = push && !full && !flush;
    assign do_pop  = pop && head_vld && !flush;

    // Control state: pointers and valids. Push and pop never target the same
    // slot in one cycle (that would need the queue to be both full and empty).
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wptr_q <= '0;
            rptr_q <= '0;
            vld_q  <= '0;
        end else begin
            if (do_push) begin
                vld_q[wr_idx] <= 1'b1;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                vld_q[rd_idx] <= 1'b0;
                rptr_q        <= rptr_q + 1'b1;
            end
        end
    end

    // Payload storage needs no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            ent_q[wr_idx] <= push_entry;
            tag_q[wr_idx] <= push_tag;
            id_q[wr_idx]  <= push_id;
        end
    end

endmodule

// File: rtl/lsu_q.sv
// Load/store unit with an in-order circular LSQ.
//   clk, rst_n          : clock, synchronous active-low reset
//   rvs_*               : op from the reservation station (valid/ready)
//   rob_head_vld/id     : current ROB head; only the matching queue head issues
//   flush               : squash everything queued and in flight
//   cdb_*               : result broadcast (valid/ready), held until accepted
//   dmem_*              : single-cycle request strobes, response on dmem_resp
// Handshakes: a transfer happens on a cycle where the valid side (rvs_req,
// cdb_req) and the ready side (rvs_rdy, cdb_rdy) are both high; cdb outputs
// stay constant while cdb_req is high and cdb_rdy is low.
// One memory access is outstanding at a time. Misaligned ops never reach
// memory; they go straight to the CDB with cdb_exc set and the faulting
// address as data.
module lsu_q
    import rv32i_types::*;
#(
    parameter  int TAG_W     = 4,
    parameter  int ROB_DEPTH = 16,
    parameter  int DEPTH     = 8,
    localparam int ROB_PTR_W = $clog2(ROB_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rvs_req,
    output logic                 rvs_rdy,
    input  logic [3:0]           rvs_opc,
    input  logic [TAG_W-1:0]     rvs_tag,
    input  logic [31:0]          rvs_src1,
    input  logic [31:0]          rvs_src2,
    input  logic [11:0]          rvs_offset,
    input  logic [ROB_PTR_W-1:0] rvs_inst_id,
    input  logic                 rob_head_vld,
    input  logic [ROB_PTR_W-1:0] rob_head_id,
    input  logic                 flush,
    output logic                 cdb_req,
    input  logic                 cdb_rdy,
    output logic [TAG_W-1:0]     cdb_tag,
    output logic [ROB_PTR_W-1:0] cdb_inst_id,
    output logic [31:0]          cdb_wdata,
    output logic                 cdb_exc,
    output logic [31:0]          dmem_addr,
    output logic [3:0]           dmem_rmask,
    output logic [3:0]           dmem_wmask,
    output logic [31:0]          dmem_wdata,
    input  logic [31:0]          dmem_rdata,
    input  logic                 dmem_resp
);

    lsu_state_t           state_q;
    lsu_op_t              op_q;
    logic [1:0]           off_q;

    lsq_entry_t           enq_entry;
    lsq_entry_t           head_entry;
    logic [TAG_W-1:0]     head_tag;
    logic [ROB_PTR_W-1:0] head_id;
    logic                 head_vld;
    logic                 q_full;
    logic                 q_empty;
    logic                 enq;
    logic                 issue;
    logic                 head_mis;

    // Effective address is formed at enqueue so the queue holds final addresses.
    always_comb begin
        enq_entry      = '0;
        enq_entry.opc  = lsu_op_t'(rvs_opc);
        enq_entry.addr = rvs_src1 + {{20{rvs_offset[11]}}, rvs_offset};
        enq_entry.data = rvs_src2;
    end

    assign rvs_rdy = rst_n && !q_full;
    assign enq     = rvs_req && rvs_rdy && !flush;

    assign issue    = head_vld && (state_q == IDLE) && rob_head_vld &&
                      (rob_head_id == head_id) && !flush;
    assign head_mis = is_misaligned(head_entry.opc, head_entry.addr[1:0]);

    lsq_fifo #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W),
        .ID_W  (ROB_PTR_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .push       (enq),
        .push_entry (enq_entry),
        .push_tag   (rvs_tag),
        .push_id    (rvs_inst_id),
        .pop        (issue),
        .full       (q_full),
        .empty      (q_empty),
        .head_vld   (head_vld),
        .head_entry (head_entry),
        .head_tag   (head_tag),
        .head_id    (head_id)
    );

    // Memory request: address and data always follow the head; the strobes
    // qualify them for exactly the issue cycle of an aligned op.
    always_comb begin
        dmem_addr  = {head_entry.addr[31:2], 2'b00};
        dmem_wdata = head_entry.data << {head_entry.addr[1:0], 3'b000};
        dmem_rmask = 4'h0;
        dmem_wmask = 4'h0;
        if (issue && !head_mis) begin
            if (is_store(head_entry.opc)) begin
                dmem_wmask = store_mask(head_entry.opc, head_entry.addr[1:0]);
            end else begin
                dmem_rmask = 4'hF;
            end
        end
    end

    // Memory-side state machine with the CDB result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= lb;
            off_q       <= 2'b00;
            cdb_req     <= 1'b0;
            cdb_exc     <= 1'b0;
            cdb_tag     <= '0;
            cdb_inst_id <= '0;
            cdb_wdata   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (issue) begin
                        op_q        <= head_entry.opc;
                        off_q       <= head_entry.addr[1:0];
                        cdb_tag     <= head_tag;
                        cdb_inst_id <= head_id;
                        if (head_mis) begin
                            state_q   <= WB;
                            cdb_req   <= 1'b1;
                            cdb_exc   <= 1'b1;
                            cdb_wdata <= head_entry.addr;
                        end else begin
                            state_q <= MEM;
                        end
                    end
                end
                MEM: begin
                    // A flushed access must still see its response before the
                    // port is reused, unless that response arrives right now.
                    if (flush) begin
                        state_q <= dmem_resp ? IDLE : DRAIN;
                    end else if (dmem_resp) begin
                        state_q   <= WB;
                        cdb_req   <= 1'b1;
                        cdb_exc   <= 1'b0;
                        cdb_wdata <= load_extract(op_q, off_q, dmem_rdata);
                    end
                end
                WB: begin
                    if (flush || cdb_rdy) begin
                        state_q <= IDLE;
                        cdb_req <= 1'b0;
                        cdb_exc <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (dmem_resp) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_q.sv
module tb_lsu_q;

    typedef struct {
        logic [3:0]  opc;
        logic [3:0]  tag;
        logic [3:0]  id;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [11:0] off;
    } op_t;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        rvs_req;
    logic        rvs_rdy;
    logic [3:0]  rvs_opc;
    logic [3:0]  rvs_tag;
    logic [31:0] rvs_src1;
    logic [31:0] rvs_src2;
    logic [11:0] rvs_offset;
    logic [3:0]  rvs_inst_id;
    logic        rob_head_vld;
    logic [3:0]  rob_head_id;
    logic        flush;
    logic        cdb_req;
    logic        cdb_rdy;
    logic [3:0]  cdb_tag;
    logic [3:0]  cdb_inst_id;
    logic [31:0] cdb_wdata;
    logic        cdb_exc;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;

    always #5 clk = ~clk;

    lsu_q dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rvs_req      (rvs_req),
        .rvs_rdy      (rvs_rdy),
        .rvs_opc      (rvs_opc),
        .rvs_tag      (rvs_tag),
        .rvs_src1     (rvs_src1),
        .rvs_src2     (rvs_src2),
        .rvs_offset   (rvs_offset),
        .rvs_inst_id  (rvs_inst_id),
        .rob_head_vld (rob_head_vld),
        .rob_head_id  (rob_head_id),
        .flush        (flush),
        .cdb_req      (cdb_req),
        .cdb_rdy      (cdb_rdy),
        .cdb_tag      (cdb_tag),
        .cdb_inst_id  (cdb_inst_id),
        .cdb_wdata    (cdb_wdata),
        .cdb_exc      (cdb_exc),
        .dmem_addr    (dmem_addr),
        .dmem_rmask   (dmem_rmask),
        .dmem_wmask   (dmem_wmask),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp)
    );

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    op_t         mq[$];        // ops the model believes are queued, in order
    logic [40:0] exp_q[$];     // expected CDB result {exc, tag, id, wdata}
    logic [3:0]  next_id = 4'd0;
    logic [3:0]  junk_id;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (spec arithmetic) ----------------
    function automatic logic [31:0] ref_addr(input op_t o);
        return o.src1 + {{20{o.off[11]}}, o.off};
    endfunction

    function automatic int op_size(input logic [3:0] opc);
        if (opc[1:0] == 2'd0) return 1;
        if (opc[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] ref_wmask(input logic [31:0] a, input int sz);
        int m;
        m = ((1 << sz) - 1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] ref_load(input logic [3:0] opc, input logic [31:0] a,
                                             input logic [31:0] rdata);
        longint unsigned v;
        longint unsigned lim;
        int bits;
        bits = 8 * op_size(opc);
        lim  = 64'd1 << bits;
        v    = (64'(rdata) >> (8 * (a % 4))) % lim;
        if (!opc[2] && bits < 32 && v >= lim / 2) v = v + (64'hFFFF_FFFF_FFFF_FFFF - lim + 1);
        return v[31:0];
    endfunction

    function automatic op_t mk_op(input logic [3:0] opc, input logic [31:0] src1,
                                  input logic [11:0] off, input logic [31:0] src2);
        op_t o;
        o.opc  = opc;
        o.tag  = 4'($urandom_range(0, 15));
        o.id   = next_id;
        o.src1 = src1;
        o.off  = off;
        o.src2 = src2;
        next_id = next_id + 4'd1;
        return o;
    endfunction

    function automatic op_t rand_op();
        logic [3:0] opcs [8];
        opcs = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10};
        return mk_op(opcs[$urandom_range(0, 7)], $urandom, 12'($urandom), $urandom);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input op_t o);
        rvs_req     = 1'b1;
        rvs_opc     = o.opc;
        rvs_tag     = o.tag;
        rvs_inst_id = o.id;
        rvs_src1    = o.src1;
        rvs_src2    = o.src2;
        rvs_offset  = o.off;
        #1;
        check("enq_rdy", rvs_rdy, 1);
        tick();
        rvs_req = 1'b0;
        mq.push_back(o);
    endtask

    task automatic drive_junk();
        rvs_req     = 1'b1;
        rvs_opc     = 4'd2;
        rvs_tag     = 4'd0;
        rvs_inst_id = junk_id;
        rvs_src1    = 32'h0000_8000;
        rvs_src2    = 32'h0;
        rvs_offset  = 12'h0;
    endtask

    task automatic check_cdb(input logic [40:0] e);
        check("cdb_req", cdb_req, 1);
        check("cdb_exc", cdb_exc, e[40]);
        check("cdb_tag", cdb_tag, e[39:36]);
        check("cdb_id", cdb_inst_id, e[35:32]);
        check("cdb_wdata", cdb_wdata, e[31:0]);
    endtask

    // Issue the model's head op, answer memory after resp_dly cycles and
    // hold off the CDB for rdy_dly cycles.
    task automatic issue_head(input logic [31:0] rdata, input int resp_dly, input int rdy_dly,
                              input bit push_junk);
        op_t         o;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] res;
        logic [40:0] e;
        bit          mis;
        int          sz;
        if (mq.size() == 0) begin
            errors++;
            $display("FAIL model_queue observed=empty expected=op");
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $fatal(1, "model queue underflow");
        end
        o   = mq.pop_front();
        a   = ref_addr(o);
        sz  = op_size(o.opc);
        mis = (a % sz) != 0;
        rob_head_vld = 1'b1;
        rob_head_id  = o.id;
        if (push_junk) drive_junk();
        #1;
        if (push_junk) check("full_blocks_enq", rvs_rdy, 0);
        if (mis) begin
            check("mis_rmask", dmem_rmask, 0);
            check("mis_wmask", dmem_wmask, 0);
            e = {1'b1, o.tag, o.id, a};
        end else begin
            check("dmem_addr", dmem_addr, {a[31:2], 2'b00});
            if (o.opc[3]) begin
                wd = o.src2 << (8 * (a % 4));
                check("st_wmask", dmem_wmask, ref_wmask(a, sz));
                check("st_rmask", dmem_rmask, 0);
                check("st_wdata", dmem_wdata, wd);
                res = 32'h0;
            end else begin
                check("ld_rmask", dmem_rmask, 4'hF);
                check("ld_wmask", dmem_wmask, 0);
                res = ref_load(o.opc, a, rdata);
            end
            e = {1'b0, o.tag, o.id, res};
        end
        exp_q.push_back(e);
        tick();
        rob_head_vld = 1'b0;
        rvs_req      = 1'b0;
        if (!mis) begin
            for (int i = 0; i < resp_dly; i++) begin
                #1;
                check("mem_wait_cdb", cdb_req, 0);
                check("mem_wait_strobe", {dmem_rmask, dmem_wmask}, 0);
                tick();
            end
            dmem_resp  = 1'b1;
            dmem_rdata = rdata;
            #1;
            check("resp_cycle_cdb", cdb_req, 0);
            tick();
            dmem_resp  = 1'b0;
            dmem_rdata = $urandom;
        end
        e = exp_q.pop_front();
        for (int i = 0; i < rdy_dly; i++) begin
            if (mq.size() > 0) begin
                rob_head_vld = 1'b1;
                rob_head_id  = mq[0].id;
            end
            #1;
            check_cdb(e);
            check("wb_no_issue", {dmem_rmask, dmem_wmask}, 0);
            tick();
        end
        rob_head_vld = 1'b0;
        cdb_rdy      = 1'b1;
        #1;
        check_cdb(e);
        tick();
        cdb_rdy = 1'b0;
        #1;
        check("cdb_drop", cdb_req, 0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        op_t o;
        op_t n;
        rst_n        = 1'b0;
        rvs_req      = 1'b0;
        rvs_opc      = 4'd0;
        rvs_tag      = 4'd0;
        rvs_src1     = 32'h0;
        rvs_src2     = 32'h0;
        rvs_offset   = 12'h0;
        rvs_inst_id  = 4'd0;
        rob_head_vld = 1'b0;
        rob_head_id  = 4'd0;
        flush        = 1'b0;
        cdb_rdy      = 1'b0;
        dmem_rdata   = 32'h0;
        dmem_resp    = 1'b0;
        junk_id      = 4'hF;

        // reset state
        repeat (2) tick();
        #1;
        check("rst_rvs_rdy", rvs_rdy, 0);
        check("rst_cdb_req", cdb_req, 0);
        check("rst_cdb_exc", cdb_exc, 0);
        check("rst_cdb_tag", cdb_tag, 0);
        check("rst_cdb_id", cdb_inst_id, 0);
        check("rst_cdb_wdata", cdb_wdata, 0);
        check("rst_masks", {dmem_rmask, dmem_wmask}, 0);
        rst_n = 1'b1;
        tick();
        check("rdy_after_rst", rvs_rdy, 1);

        // sw 0x1000+4, then lb/lhu byte extraction, then misaligned lw
        enq(mk_op(4'd10, 32'h0000_1000, 12'd4, 32'hDEAD_BEEF));
        issue_head($urandom, 1, 0, 0);
        enq(mk_op(4'd0, 32'h0000_2000, 12'd3, 32'h0));
        issue_head(32'h8011_2233, 0, 0, 0);
        enq(mk_op(4'd5, 32'h0000_2004, 12'hFFE, 32'h0));
        issue_head(32'h8011_2233, 2, 1, 0);
        enq(mk_op(4'd2, 32'h0000_3000, 12'd2, 32'h0));
        issue_head($urandom, 0, 0, 0);

        // fill to full with the ROB head pointing elsewhere
        rob_head_vld = 1'b1;
        rob_head_id  = next_id + 4'd8;
        for (int i = 0; i < 8; i++) enq(rand_op());
        #1;
        check("full_rdy_low", rvs_rdy, 0);
        check("no_issue_mismatch", {dmem_rmask, dmem_wmask}, 0);
        junk_id = next_id + 4'd9;
        tick();
        issue_head($urandom, $urandom_range(0, 2), 0, 1);
        for (int i = 0; i < 7; i++) issue_head($urandom, $urandom_range(0, 3), $urandom_range(0, 2), 0);
        // the blocked op must not have been queued
        for (int i = 0; i < 3; i++) begin
            rob_head_vld = 1'b1;
            rob_head_id  = junk_id;
            #1;
            check("empty_no_strobe", {dmem_rmask, dmem_wmask}, 0);
            check("empty_no_cdb", cdb_req, 0);
            tick();
        end
        rob_head_vld = 1'b0;

        // order preserved across pointer wrap, randomized ops and latencies
        for (int i = 0; i < 20; i++) begin
            enq(rand_op());
            if (i % 4 == 0) enq(rand_op());
            while (mq.size() > (i % 4 == 3 ? 0 : 1))
                issue_head($urandom, $urandom_range(0, 3),
                           ($urandom_range(0, 4) == 0) ? 5 : $urandom_range(0, 2), 0);
        end
        while (mq.size() > 0) issue_head($urandom, 1, 0, 0);

        // CDB back-pressure for 5 cycles with another op ready behind it
        enq(mk_op(4'd2, 32'h0000_5000, 12'd8, 32'h0));
        enq(mk_op(4'd8, 32'h0000_5000, 12'd1, 32'h0000_00A5));
        issue_head(32'h1234_5678, 1, 5, 0);
        issue_head($urandom, 0, 0, 0);

        // flush while a load is in MEM; response arrives 3 cycles after flush
        enq(mk_op(4'd2, 32'h0000_4000, 12'd0, 32'h0));
        enq(rand_op());
        enq(rand_op());
        o = mq.pop_front();
        rob_head_vld = 1'b1;
        rob_head_id  = o.id;
        #1;
        check("fl_rmask", dmem_rmask, 4'hF);
        tick();
        rob_head_vld = 1'b0;
        tick();
        flush   = 1'b1;
        junk_id = next_id + 4'd5;
        drive_junk();
        #1;
        check("fl_no_strobe", {dmem_rmask, dmem_wmask}, 0);
        tick();
        flush   = 1'b0;
        rvs_req = 1'b0;
        mq.delete();
        n = rand_op();
        enq(n);
        rob_head_vld = 1'b1;
        rob_head_id  = n.id;
        #1;
        check("drain_no_strobe", {dmem_rmask, dmem_wmask}, 0);
        check("drain_no_cdb", cdb_req, 0);
        tick();
        dmem_resp  = 1'b1;
        dmem_rdata = $urandom;
        #1;
        check("drain_resp_no_strobe", {dmem_rmask, dmem_wmask}, 0);
        tick();
        dmem_resp    = 1'b0;
        rob_head_vld = 1'b0;
        #1;
        check("drain_done_no_cdb", cdb_req, 0);
        issue_head($urandom, 1, 0, 0);

        // flush while the result waits in WB
        enq(mk_op(4'd2, 32'h0000_6000, 12'd0, 32'h0));
        o = mq.pop_front();
        rob_head_vld = 1'b1;
        rob_head_id  = o.id;
        tick();
        rob_head_vld = 1'b0;
        dmem_resp    = 1'b1;
        dmem_rdata   = 32'hCAFE_F00D;
        tick();
        dmem_resp = 1'b0;
        #1;
        check("wb_cdb_req", cdb_req, 1);
        check("wb_cdb_wdata", cdb_wdata, 32'hCAFE_F00D);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check("wb_flush_drop", cdb_req, 0);

        // unit still works afterwards
        enq(rand_op());
        issue_head($urandom, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_q.md
Name: lsu_q

Overview:
- Second-generation load/store unit with a parametrised circular LSQ.
- Sits between the LSU reservation station, the ROB head, the CDB and the data-memory port.
- Issues one memory access at a time, in program order, only when the queue head is the ROB head.
- Adds over the previous generation:
  - CDB back-pressure with result hold.
  - Misaligned-access detection with an exception flag.
  - Pipeline flush, including draining an in-flight access.

Parameters:
- TAG_W, 4, physical-register tag width.
- ROB_DEPTH, 16, ROB entries; ROB_PTR_W = $clog2(ROB_DEPTH).
- DEPTH, 8, LSQ entries; power of two, ≥2; PTR_W = $clog2(DEPTH).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- rvs_req  in  1  RS presents an op
- rvs_rdy  out  1  LSQ can accept
- rvs_opc  in  4  lsu_op_t
- rvs_tag  in  TAG_W  destination tag
- rvs_src1  in  32  base
- rvs_src2  in  32  store data
- rvs_offset  in  12  signed immediate
- rvs_inst_id  in  ROB_PTR_W  ROB index
- rob_head_vld  in  1  ROB head valid
- rob_head_id  in  ROB_PTR_W  ROB head index
- flush  in  1  squash all queued/in-flight ops
- cdb_req  out  1  result valid
- cdb_rdy  in  1  CDB accepts
- cdb_tag  out  TAG_W
- cdb_inst_id  out  ROB_PTR_W
- cdb_wdata  out  32  load data, or faulting address when cdb_exc
- cdb_exc  out  1  misaligned-access exception
- dmem_addr  out  32  word-aligned address
- dmem_rmask  out  4
- dmem_wmask  out  4
- dmem_wdata  out  32
- dmem_rdata  in  32
- dmem_resp  in  1

Behaviour:
- Reset: rst_n=0 at posedge clears everything.
  - Pointers, entry valids, state=IDLE, cdb_req/cdb_exc=0, cdb_tag/inst_id/wdata=0.
  - dmem masks are 0 whenever state≠IDLE or no issue occurs.
  - rvs_rdy=0 while rst_n=0.
- Enqueue: accepted when rvs_req && rvs_rdy && !flush.
  - addr = src1 + sext(offset), mod 2^32.
  - Entry stores opc, tag, addr, src2, inst_id.
  - rvs_rdy = !full.
  - Pointers carry an extra wrap bit: full = low bits equal and wrap bits differ; empty = both equal.
  - Wrap from DEPTH-1 to 0 is transparent.
- Head eligible: head valid && state==IDLE && rob_head_vld && rob_head_id==head.inst_id && !flush.
- Misalignment (checked at issue):
  - lh/lhu/sh misaligned when addr[0]=1.
  - lw/sw misaligned when addr[1:0]≠0.
  - Byte ops are never misaligned.
- Issue: eligible head is dequeued that cycle; rptr advances.
  - Aligned: dmem_rmask=4'hF (loads) or dmem_wmask=byte-lane mask (stores) for exactly that one cycle.
  - dmem_wdata is lane-shifted; dmem_addr = {addr[31:2],2'b0}. Go to MEM.
  - Misaligned: no dmem strobe; capture exc=1, wdata=addr; go to WB.
- State machine:
  - IDLE → MEM (aligned issue), IDLE → WB (misaligned issue).
  - MEM → WB on dmem_resp; latch extracted load data (lb/lbu/lh/lhu sign/zero-extend by captured addr[1:0]; stores yield 0); exc=0.
  - WB: cdb_req=1, outputs held stable until cdb_rdy; on cdb_rdy → IDLE.
  - DRAIN: wait dmem_resp, discard data, → IDLE.
- Latency: aligned op issued in cycle I with resp in cycle R drives cdb_req from R+1. Minimum enqueue→issue is 1 cycle.
- Flush (highest priority):
  - Empties queue (all valids=0, wptr=rptr=0); same-cycle enqueue dropped; no issue that cycle.
  - MEM → DRAIN; if dmem_resp coincides, → IDLE directly.
  - WB → IDLE, cdb_req drops next cycle.
  - DRAIN stays DRAIN.
- Simultaneous enqueue+issue: both take effect; count unchanged. When full, enqueue is blocked even if an issue frees a slot that cycle.
- Stores report completion through the CDB (wdata=0) so the ROB marks them done.

Decomposition:
- Shared package rv32i_types holds:
  - lsu_op_t: lb=0, lh=1, lw=2, lbu=4, lhu=5, sb=8, sh=9, sw=10; opc[3]=store.
  - lsq_entry_t struct.
  - lsu_state_t enum {IDLE, MEM, WB, DRAIN}.
- Sub-module lsq_fifo: entries, pointers, full/empty, flush clear. Head data is exposed combinationally.
- FSM, alignment check, lane logic and CDB hold register live in lsu_q.

Test Plan:
- sw src1=0x1000 off=4 data=0xDEADBEEF, head matches → dmem_addr=0x1004, wmask=F, wdata=0xDEADBEEF; after resp, cdb_req with wdata=0, exc=0.
- lb addr=0x2003, rdata=0x80112233 → cdb_wdata=0xFFFFFF80; lhu addr=0x2002, same rdata → 0x00008011.
- lw addr=0x3002 → no dmem strobe; cdb_req next cycle with exc=1, wdata=0x00003002.
- Fill 8 entries with head id mismatched → rvs_rdy=0 after 8th accept; match head → one issue per op; order preserved across pointer wrap over 20 ops.
- Load in MEM, assert flush, resp 3 cycles later → no cdb_req; queue empty; new op accepted next cycle.
- cdb_rdy held 0 for 5 cycles in WB → cdb outputs stable, no further issue; release → IDLE, next op issues.
